// File: rtl/vga_sync_monitor_if.sv
// Sync inputs and recovered-timing outputs of the VGA sync monitor.
// master: the side that drives the sync stream and reads status.
// slave: the monitor itself.
interface vga_sync_monitor_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       err_clr;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       frame_start;
  logic       locked;
  logic       err_h;
  logic       err_v;

  modport master (
    output pix_en, hsync, vsync, err_clr,
    input  x, y, active, frame_start, locked, err_h, err_v
  );

  modport slave (
    input  pix_en, hsync, vsync, err_clr,
    output x, y, active, frame_start, locked, err_h, err_v
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Purpose: recover pixel coordinates from hsync/vsync, check timing, report lock/errors.
// Latency: x/y/active combinational from the counters; frame_start/locked/err_* one clk after the tick.
// Backpressure: none; every pix_en tick is consumed, pix_en low freezes all state except err_clr.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_PULSE     = 96,
  parameter int H_BP        = 144,
  parameter int H_FP        = 784,
  parameter int V_TOTAL     = 521,
  parameter int V_PULSE     = 2,
  parameter int V_BP        = 31,
  parameter int V_FP        = 511,
  parameter int LOCK_FRAMES = 2
) (
  input logic               clk,
  input logic               rst,
  vga_sync_monitor_if.slave bus
);

  localparam logic [9:0] HT_M1   = 10'(H_TOTAL - 1);
  localparam logic [9:0] HP_M1   = 10'(H_PULSE - 1);
  localparam logic [9:0] HBP     = 10'(H_BP);
  localparam logic [9:0] HFP     = 10'(H_FP);
  localparam logic [9:0] VT_M1   = 10'(V_TOTAL - 1);
  localparam logic [9:0] VP_M1   = 10'(V_PULSE - 1);
  localparam logic [9:0] VBP     = 10'(V_BP);
  localparam logic [9:0] VFP     = 10'(V_FP);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  // good_cnt must be able to hold LOCK_FRAMES itself
  localparam int             GW     = $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0]  LOCK_N = GW'(LOCK_FRAMES);
  localparam logic [GW-1:0]  ONE_G  = GW'(1);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} lock_state_t;

  logic [9:0]    hc, vc;
  logic          h_prev, v_prev;
  logic          h_seen, v_seen;
  logic          hfall, hrise, vfall, vrise;
  logic          h_err, v_err, any_err;
  logic          in_win;
  lock_state_t   state;
  logic [GW-1:0] good_cnt;
  logic          frame_bad;
  logic          frame_start_q, locked_q, err_h_q, err_v_q;

  // Edge detection and timing checks; everything is qualified by the pixel tick.
  // Vertical edges are only looked at on hsync falling edges.
  always_comb begin
    hfall   = bus.pix_en & h_prev & ~bus.hsync;
    hrise   = bus.pix_en & ~h_prev & bus.hsync;
    vfall   = hfall & v_prev & ~bus.vsync;
    vrise   = hfall & ~v_prev & bus.vsync;
    // The very first falling edge after reset has no reference line to measure.
    h_err   = (hfall & h_seen & (hc != HT_M1)) | (hrise & (hc != HP_M1));
    v_err   = (vfall & v_seen & (vc != VT_M1)) | (vrise & (vc != VP_M1));
    any_err = h_err | v_err;
  end

  // Horizontal counter: restarts on hsync fall, saturates so a dead sync never aliases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc     <= '0;
      h_prev <= 1'b1;
      h_seen <= 1'b0;
    end else if (bus.pix_en) begin
      h_prev <= bus.hsync;
      if (hfall) begin
        hc     <= '0;
        h_seen <= 1'b1;
      end else if (hc != CNT_MAX) begin
        hc <= hc + 10'd1;
      end
    end
  end

  // Vertical counter: steps once per line (hsync fall), restarts on vsync fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vc     <= '0;
      v_prev <= 1'b1;
      v_seen <= 1'b0;
    end else if (hfall) begin
      v_prev <= bus.vsync;
      if (vfall) begin
        vc     <= '0;
        v_seen <= 1'b1;
      end else if (vc != CNT_MAX) begin
        vc <= vc + 10'd1;
      end
    end
  end

  // Frame pulse and sticky error flags; a new error outranks a clear in the same clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_start_q <= 1'b0;
      err_h_q       <= 1'b0;
      err_v_q       <= 1'b0;
    end else begin
      frame_start_q <= vfall;
      if (h_err)            err_h_q <= 1'b1;
      else if (bus.err_clr) err_h_q <= 1'b0;
      if (v_err)            err_v_q <= 1'b1;
      else if (bus.err_clr) err_v_q <= 1'b0;
    end
  end

  // Lock FSM: needs LOCK_FRAMES clean frames in a row after the first vsync fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEARCH;
      good_cnt  <= '0;
      frame_bad <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (vfall) begin
            state     <= TRACK;
            good_cnt  <= '0;
            frame_bad <= 1'b0;
          end
        end
        TRACK: begin
          if (vfall) begin
            frame_bad <= 1'b0;
            // An error on the closing edge belongs to the frame being closed.
            if (frame_bad | any_err) begin
              good_cnt <= '0;
            end else if (good_cnt == LOCK_N - ONE_G) begin
              good_cnt <= LOCK_N;
              state    <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              good_cnt <= good_cnt + ONE_G;
            end
          end else if (any_err) begin
            frame_bad <= 1'b1;
          end
        end
        LOCKED: begin
          if (any_err) begin
            state    <= SEARCH;
            good_cnt <= '0;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state    <= SEARCH;
          good_cnt <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // Active window decode from the recovered counters.
  always_comb begin
    in_win = (hc >= HBP) && (hc < HFP) && (vc >= VBP) && (vc < VFP);
  end

  assign bus.active      = in_win;
  assign bus.x           = in_win ? hc - HBP : '0;
  assign bus.y           = in_win ? vc - VBP : '0;
  assign bus.frame_start = frame_start_q;
  assign bus.locked      = locked_q;
  assign bus.err_h       = err_h_q;
  assign bus.err_v       = err_v_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor with a scaled-down timing so full frames stay short.
// Expected outputs come from a timestamp-based model of the sync stream.
module tb_vga_sync_monitor;
  localparam int H_TOTAL = 40, H_PULSE = 6, H_BP = 10, H_FP = 34;
  localparam int V_TOTAL = 20, V_PULSE = 2, V_BP = 4,  V_FP = 18;
  localparam int LOCK_FRAMES = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_sync_monitor_if bus ();

  vga_sync_monitor #(
    .H_TOTAL(H_TOTAL), .H_PULSE(H_PULSE), .H_BP(H_BP), .H_FP(H_FP),
    .V_TOTAL(V_TOTAL), .V_PULSE(V_PULSE), .V_BP(V_BP), .V_FP(V_FP),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       frame_start;
    logic       locked;
    logic       err_h;
    logic       err_v;
  } obs_t;

  obs_t expq[$];
  int checks   = 0;
  int failures = 0;
  int fs_cnt   = 0;

  // Reference model state: times of sync edges rather than counters.
  int m_t;       // ticks since reset
  int m_hf;      // tick index of the last hsync fall (-1 = reset)
  bit m_hl, m_hseen;
  int m_lines;   // hsync falls since reset
  int m_vmark;   // value of m_lines at the last vsync fall
  bit m_vl, m_vseen;
  bit m_eh, m_ev;
  int m_mode;    // 0 searching, 1 tracking, 2 locked
  int m_good;
  bit m_bad;
  int m_vfalls;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_hf = -1; m_hl = 1'b1; m_hseen = 1'b0;
    m_lines = 0; m_vmark = 0; m_vl = 1'b1; m_vseen = 1'b0;
    m_eh = 1'b0; m_ev = 1'b0;
    m_mode = 0; m_good = 0; m_bad = 1'b0; m_vfalls = 0;
  endtask

  task automatic model_tick(input bit hs, input bit vs, input bit clr, output obs_t o);
    bit hf, hr, vf, vr, herr, verr;
    int hc, vc, nl;
    hf = m_hl && !hs;
    hr = !m_hl && hs;
    m_hl = hs;
    vf = 1'b0; vr = 1'b0; herr = 1'b0; verr = 1'b0;
    // line length = ticks between hsync falls; pulse width = ticks from fall to rise
    if (hf && m_hseen && (m_t - m_hf) != H_TOTAL) herr = 1'b1;
    if (hr && (m_t - m_hf) != H_PULSE) herr = 1'b1;
    if (hf) begin
      m_hf = m_t;
      m_hseen = 1'b1;
      vf = m_vl && !vs;
      vr = !m_vl && vs;
      m_vl = vs;
      m_lines++;
      nl = m_lines - m_vmark;
      if (vf && m_vseen && nl != V_TOTAL) verr = 1'b1;
      if (vr && nl != V_PULSE) verr = 1'b1;
      if (vf) begin
        m_vmark = m_lines;
        m_vseen = 1'b1;
        m_vfalls++;
      end
    end
    case (m_mode)
      0: if (vf) begin m_mode = 1; m_good = 0; m_bad = 1'b0; end
      1: begin
        if (vf) begin
          if (m_bad || herr || verr) m_good = 0;
          else begin
            m_good++;
            if (m_good == LOCK_FRAMES) m_mode = 2;
          end
          m_bad = 1'b0;
        end else if (herr || verr) m_bad = 1'b1;
      end
      default: if (herr || verr) begin m_mode = 0; m_good = 0; end
    endcase
    if (herr) m_eh = 1'b1; else if (clr) m_eh = 1'b0;
    if (verr) m_ev = 1'b1; else if (clr) m_ev = 1'b0;
    hc = (m_t - m_hf > 1023) ? 1023 : m_t - m_hf;
    vc = (m_lines - m_vmark > 1023) ? 1023 : m_lines - m_vmark;
    m_t++;
    o.active      = (hc >= H_BP) && (hc < H_FP) && (vc >= V_BP) && (vc < V_FP);
    o.x           = o.active ? 10'(hc - H_BP) : 10'd0;
    o.y           = o.active ? 10'(vc - V_BP) : 10'd0;
    o.frame_start = vf;
    o.locked      = (m_mode == 2);
    o.err_h       = m_eh;
    o.err_v       = m_ev;
  endtask

  // One pixel tick after a random idle gap; expectation queued for the monitor.
  task automatic tick(input bit hs, input bit vs, input bit clr);
    int gap;
    obs_t e;
    gap = $urandom_range(0, 3);
    repeat (gap) @(negedge clk);
    bus.pix_en  = 1'b1;
    bus.hsync   = hs;
    bus.vsync   = vs;
    bus.err_clr = clr;
    model_tick(hs, vs, clr, e);
    expq.push_back(e);
    @(negedge clk);
    bus.pix_en  = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic send_frame(input int nlines, input int vpulse, input int long_line,
                            input int wide_line, input int pause_line, input bit rnd,
                            input bit corners);
    int len, pw;
    bit vs;
    for (int l = 0; l < nlines; l++) begin
      len = H_TOTAL;
      pw  = H_PULSE;
      vs  = (l >= vpulse);
      if (l == long_line) len = H_TOTAL + 1;
      if (l == wide_line) pw = H_PULSE + 1;
      if (rnd) begin
        if ($urandom_range(0, 3) == 0) len = H_TOTAL - 2 + int'($urandom_range(0, 4));
        if ($urandom_range(0, 3) == 0) pw = H_PULSE - 1 + int'($urandom_range(0, 2));
      end
      for (int i = 0; i < len; i++) begin
        tick(i >= pw, vs, (l == wide_line) && (i == pw));
        if (l == wide_line && i == pw) chk("clr_vs_set_err_h", 32'(bus.err_h), 32'd1);
        if (corners && l == V_BP && i == H_BP) begin
          chk("corner_first_active", 32'(bus.active), 32'd1);
          chk("corner_first_x", 32'(bus.x), 32'd0);
          chk("corner_first_y", 32'(bus.y), 32'd0);
        end
        if (corners && l == V_FP - 1 && i == H_FP - 1) begin
          chk("corner_last_x", 32'(bus.x), 32'(H_FP - H_BP - 1));
          chk("corner_last_y", 32'(bus.y), 32'(V_FP - V_BP - 1));
        end
        if (l == pause_line && i == H_BP + 5) begin
          repeat (1000) @(negedge clk);
          chk("pause_x", 32'(bus.x), 32'd5);
          chk("pause_y", 32'(bus.y), 32'(l - V_BP));
          chk("pause_active", 32'(bus.active), 32'd1);
          chk("pause_locked", 32'(bus.locked), 32'd1);
          chk("pause_err_h", 32'(bus.err_h), 32'(m_eh));
          chk("pause_err_v", 32'(bus.err_v), 32'(m_ev));
        end
      end
    end
  endtask

  task automatic clear_errs();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    m_eh = 1'b0;
    m_ev = 1'b0;
    chk("clear_err_h", 32'(bus.err_h), 32'd0);
    chk("clear_err_v", 32'(bus.err_v), 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_x", 32'(bus.x), 32'd0);
    chk("reset_y", 32'(bus.y), 32'd0);
    chk("reset_active", 32'(bus.active), 32'd0);
    chk("reset_locked", 32'(bus.locked), 32'd0);
    chk("reset_err_h", 32'(bus.err_h), 32'd0);
    chk("reset_err_v", 32'(bus.err_v), 32'd0);
    expq.delete();
    model_reset();
    repeat (2) @(negedge clk);
    fs_cnt = 0;
    rst = 1'b1;
  endtask

  // Scoreboard monitor: after every tick edge, pop the model's expectation and compare.
  always @(posedge clk) begin
    obs_t e, a;
    if (rst && bus.pix_en) begin
      #1;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tick_queue: got empty queue, expected a pending entry");
      end else begin
        e = expq.pop_front();
        a = {bus.x, bus.y, bus.active, bus.frame_start, bus.locked, bus.err_h, bus.err_v};
        chk("tick_obs", 32'(a), 32'(e));
      end
    end
  end

  // Width of frame_start pulses: each high clk is counted.
  always @(negedge clk) begin
    if (rst && bus.frame_start) fs_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected summary before timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.pix_en = 1'b0; bus.hsync = 1'b1; bus.vsync = 1'b1; bus.err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Partial random stream, then reset in the middle of it
    send_frame(8, V_PULSE, -1, -1, -1, 1'b1, 1'b0);
    reset_dut();

    // Nominal timing: lock on the third vsync fall
    repeat (3) send_frame(V_TOTAL, V_PULSE, -1, -1, -1, 1'b0, 1'b1);
    chk("nominal_frame_starts", 32'(fs_cnt), 32'd3);
    chk("nominal_locked", 32'(bus.locked), 32'd1);

    // Long pause mid-line while locked
    send_frame(V_TOTAL, V_PULSE, -1, -1, 8, 1'b0, 1'b1);

    // One overlong line breaks lock; sticky err_h; relock after three clean vfalls
    send_frame(V_TOTAL, V_PULSE, 7, -1, -1, 1'b0, 1'b1);
    chk("long_line_err_h", 32'(bus.err_h), 32'd1);
    chk("long_line_unlocked", 32'(bus.locked), 32'd0);
    repeat (3) send_frame(V_TOTAL, V_PULSE, -1, -1, -1, 1'b0, 1'b1);
    chk("relock_locked", 32'(bus.locked), 32'd1);
    chk("relock_err_h_sticky", 32'(bus.err_h), 32'd1);
    clear_errs();

    // vsync held low for three lines
    send_frame(V_TOTAL, 3, -1, -1, -1, 1'b0, 1'b1);
    chk("vpulse_err_v", 32'(bus.err_v), 32'd1);
    chk("vpulse_err_h", 32'(bus.err_h), 32'd0);
    chk("vpulse_unlocked", 32'(bus.locked), 32'd0);
    clear_errs();

    // Wide hsync pulse with err_clr on the detecting tick
    send_frame(V_TOTAL, V_PULSE, -1, 5, -1, 1'b0, 1'b1);

    // Randomly perturbed frames
    repeat (3) send_frame(V_TOTAL, int'($urandom_range(1, 3)), -1, -1, -1, 1'b1, 1'b0);

    // hsync disappears mid-frame inside the active rows: counter must saturate
    send_frame(10, V_PULSE, -1, -1, -1, 1'b0, 1'b0);
    for (int i = 0; i < 1100; i++) tick(1'b1, 1'b1, 1'b0);
    chk("dead_sync_active", 32'(bus.active), 32'd0);
    chk("dead_sync_x", 32'(bus.x), 32'd0);

    // Clean timing again must reacquire lock
    repeat (4) send_frame(V_TOTAL, V_PULSE, -1, -1, -1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    chk("final_locked", 32'(bus.locked), 32'd1);

    repeat (2) @(negedge clk);
    chk("frame_start_total", 32'(fs_cnt), 32'(m_vfalls));
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
